// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment scan driver.
//   - state_t    : scan FSM state encoding (IDLE / BLANK / SHOW)
//   - NUM_DIGITS : number of multiplexed digits
//   - SEG_TABLE  : active-high gfedcba patterns for nibbles 0..F
//                  (A..F map to a dash)
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_DASH = 7'h40;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
  };

endpackage

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// bcd_to_seg7: combinational nibble to seven-segment decoder.
//   nibble  in  4  BCD digit (A..F render as a dash)
//   blank   in  1  1 = force all segments off
//   pattern out 7  active-high segments, [0]=a ... [6]=g
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = blank ? 7'h00 : SEG_TABLE[nibble];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexes a 4-digit packed-BCD value onto a
// common-anode seven-segment display.
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   disp_en     in   1 = scan, 0 = all digits dark
//   bcd_in      in   16-bit packed BCD, [3:0] = rightmost digit
//   dp_in       in   decimal point per digit
//   lz_blank    in   1 = blank leading zeros
//   an          out  anode enables, bit i = digit i
//   seg         out  segments a..g
//   dp          out  decimal point segment
//   frame_start out  one-cycle pulse when a new snapshot is taken
// Each digit slot is SCAN_DIV cycles: BLANK_CYC dark cycles followed by
// the lit portion. Inputs are sampled only at frame boundaries so a frame
// never mixes two values.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV    = 50000,
  parameter int BLANK_CYC   = 500,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  disp_en,
  input  logic [15:0]           bcd_in,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic                  lz_blank,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] SLOT_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_LAST = (BLANK_CYC > 0) ? PW'(BLANK_CYC - 1) : '0;

  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACT_LOW != 0) ? '1 : '0;
  localparam logic [6:0]            SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = (SEG_ACT_LOW != 0);

  state_t                state;
  logic [PW-1:0]         presc;
  logic [1:0]            idx;
  logic [15:0]           sh_bcd;
  logic [NUM_DIGITS-1:0] sh_dp;
  logic                  sh_lz;

  logic [3:0]            cur_nib;
  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  cur_blank;
  logic [6:0]            cur_pat;
  logic [NUM_DIGITS-1:0] an_hot;

  // lead_zero[i]: digit i and every digit above it are zero. Digit 0 is
  // never blanked, so its bit is forced low.
  always_comb begin
    lead_zero[3] = (sh_bcd[15:12] == 4'h0);
    lead_zero[2] = lead_zero[3] && (sh_bcd[11:8] == 4'h0);
    lead_zero[1] = lead_zero[2] && (sh_bcd[7:4] == 4'h0);
    lead_zero[0] = 1'b0;
    cur_nib      = sh_bcd[{idx, 2'b00} +: 4];
    cur_blank    = sh_lz && lead_zero[idx];
    an_hot       = NUM_DIGITS'(1) << idx;
  end

  bcd_to_seg7 u_dec (
    .nibble  (cur_nib),
    .blank   (cur_blank),
    .pattern (cur_pat)
  );

  // Scan control: prescaler, FSM, digit index and frame snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      presc       <= '0;
      idx         <= '0;
      sh_bcd      <= '0;
      sh_dp       <= '0;
      sh_lz       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (!disp_en) begin
        state <= ST_IDLE;
        presc <= '0;
        idx   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            sh_bcd      <= bcd_in;
            sh_dp       <= dp_in;
            sh_lz       <= lz_blank;
            idx         <= '0;
            presc       <= '0;
            frame_start <= 1'b1;
            if (BLANK_CYC == 0) state <= ST_SHOW;
            else                state <= ST_BLANK;
          end
          ST_BLANK: begin
            presc <= presc + 1'b1;
            if (presc == BLANK_LAST) state <= ST_SHOW;
          end
          ST_SHOW: begin
            if (presc == SLOT_LAST) begin
              presc <= '0;
              idx   <= idx + 1'b1;
              if (BLANK_CYC == 0) state <= ST_SHOW;
              else                state <= ST_BLANK;
              // Last digit finished: take the next frame's snapshot.
              if (idx == 2'd3) begin
                sh_bcd      <= bcd_in;
                sh_dp       <= dp_in;
                sh_lz       <= lz_blank;
                frame_start <= 1'b1;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            presc <= '0;
          end
        endcase
      end
    end
  end

  // Output registers: pins follow the scan state one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= DP_OFF;
    end else if (state == ST_SHOW) begin
      an  <= (AN_ACT_LOW != 0)  ? ~an_hot     : an_hot;
      seg <= (SEG_ACT_LOW != 0) ? ~cur_pat    : cur_pat;
      dp  <= (SEG_ACT_LOW != 0) ? ~sh_dp[idx] : sh_dp[idx];
    end else begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= DP_OFF;
    end
  end

endmodule
